// File: rtl/button_reader_pkg.sv
// Shared types and constants for the button reader: event kinds, event record and FIFO geometry.
// The long-press feature is enabled by defining BUTTON_READER_LONGPRESS_EN.
package button_reader_pkg;

  localparam int FIFO_DEPTH = 4;
  localparam int PTR_W      = 2;
  localparam int CNT_W      = 3;

  typedef enum logic [1:0] {
    KIND_PRESS   = 2'b00,
    KIND_RELEASE = 2'b01,
    KIND_LONG    = 2'b10
  } evt_kind_e;

  typedef struct packed {
    logic [3:0] idx;
    evt_kind_e  kind;
  } evt_t;

endpackage

// File: rtl/btn_debounce.sv
// One button: 2-flop synchronizer, polarity fix, debounce counter, edge pulses and,
// when BUTTON_READER_LONGPRESS_EN is defined, a long-press counter.
module btn_debounce
  import button_reader_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1600000,
  parameter bit BTN_ACTIVE_LOW  = 1'b1,
  parameter int LONG_CYCLES     = 160000000
) (
  input  logic clkin,
  input  logic resetn,
  input  logic raw_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o,
  output logic long_o
);

  localparam int DB_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  if (DEBOUNCE_CYCLES < 2 || LONG_CYCLES < 2) begin : g_param_check
    $error("btn_debounce: DEBOUNCE_CYCLES and LONG_CYCLES must be at least 2");
  end

  logic            sync1_q, sync2_q;
  logic            pressed;
  logic            level_q, level_d;
  logic [DB_W-1:0] db_cnt_q, db_cnt_d;
  logic            flip;

  // Synchronizer resets to the idle pin level so reset release never looks like a press.
  always_ff @(posedge clkin or negedge resetn) begin
    if (!resetn) begin
      sync1_q  <= BTN_ACTIVE_LOW;
      sync2_q  <= BTN_ACTIVE_LOW;
      level_q  <= 1'b0;
      db_cnt_q <= '0;
    end else begin
      sync1_q  <= raw_i;
      sync2_q  <= sync1_q;
      level_q  <= level_d;
      db_cnt_q <= db_cnt_d;
    end
  end

  assign pressed = sync2_q ^ BTN_ACTIVE_LOW;

  always_comb begin
    level_d  = level_q;
    db_cnt_d = '0;
    flip     = 1'b0;
    if (pressed != level_q) begin
      if (db_cnt_q == DB_LAST) begin
        flip    = 1'b1;
        level_d = pressed;
      end else begin
        db_cnt_d = db_cnt_q + DB_W'(1);
      end
    end
  end

  assign level_o = level_q;
  assign rise_o  = flip & pressed;
  assign fall_o  = flip & ~pressed;

`ifdef BUTTON_READER_LONGPRESS_EN
  localparam int LP_W = (LONG_CYCLES > 2) ? $clog2(LONG_CYCLES) : 1;
  localparam logic [LP_W-1:0] LP_LAST = LP_W'(LONG_CYCLES - 1);

  logic [LP_W-1:0] lp_cnt_q, lp_cnt_d;
  logic            lp_done_q, lp_done_d;
  logic            lp_hit;

  always_ff @(posedge clkin or negedge resetn) begin
    if (!resetn) begin
      lp_cnt_q  <= '0;
      lp_done_q <= 1'b0;
    end else begin
      lp_cnt_q  <= lp_cnt_d;
      lp_done_q <= lp_done_d;
    end
  end

  // Counter saturates once fired; a release landing on the same cycle wins over the long event.
  always_comb begin
    lp_cnt_d  = lp_cnt_q;
    lp_done_d = lp_done_q;
    lp_hit    = 1'b0;
    if (!level_q) begin
      lp_cnt_d  = '0;
      lp_done_d = 1'b0;
    end else if (!lp_done_q) begin
      if (lp_cnt_q == LP_LAST) begin
        lp_hit    = ~flip;
        lp_done_d = 1'b1;
      end else begin
        lp_cnt_d = lp_cnt_q + LP_W'(1);
      end
    end
  end

  assign long_o = lp_hit;
`else
  assign long_o = 1'b0;
`endif

endmodule

// File: rtl/button_reader.sv
// Debounced push-button reader: per-button pending slots, lowest-index arbiter and 4-entry event FIFO.
// Long-press events exist only when BUTTON_READER_LONGPRESS_EN is defined.
module button_reader
  import button_reader_pkg::*;
#(
  parameter int N_BTN           = 4,
  parameter int DEBOUNCE_CYCLES = 1600000,
  parameter bit BTN_ACTIVE_LOW  = 1'b1,
  parameter int LONG_CYCLES     = 160000000
) (
  input  logic             clkin,
  input  logic             resetn,
  input  logic             enable,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [3:0]       evt_idx,
  output logic [1:0]       evt_kind,
  output logic             overflow,
  input  logic             clr_overflow
);

  if (N_BTN < 1 || N_BTN > 16) begin : g_param_check
    $error("button_reader: N_BTN must be within 1..16");
  end

  logic [N_BTN-1:0] new_ev;
  evt_kind_e        new_kind [N_BTN];

  for (genvar gi = 0; gi < N_BTN; gi++) begin : g_btn
    logic rise, fall, lng;

    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .BTN_ACTIVE_LOW (BTN_ACTIVE_LOW),
      .LONG_CYCLES    (LONG_CYCLES)
    ) u_deb (
      .clkin  (clkin),
      .resetn (resetn),
      .raw_i  (btn_raw[gi]),
      .level_o(btn_level[gi]),
      .rise_o (rise),
      .fall_o (fall),
      .long_o (lng)
    );

    assign new_ev[gi]   = rise | fall | lng;
    assign new_kind[gi] = rise ? KIND_PRESS : (fall ? KIND_RELEASE : KIND_LONG);
  end

  logic [N_BTN-1:0] pend_v_q, pend_v_d;
  evt_kind_e        pend_k_q [N_BTN];
  evt_kind_e        pend_k_d [N_BTN];
  logic             overflow_q, overflow_d;

  evt_t             mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q, count_d;

  logic             push_hit, push, pop, full, ovf_set;
  logic [3:0]       push_sel;
  evt_kind_e        push_kind;

  // Lowest occupied slot wins; descending scan lets the last match stand.
  always_comb begin
    push_hit  = 1'b0;
    push_sel  = '0;
    push_kind = KIND_PRESS;
    for (int i = N_BTN - 1; i >= 0; i--) begin
      if (pend_v_q[i]) begin
        push_hit  = 1'b1;
        push_sel  = 4'(i);
        push_kind = pend_k_q[i];
      end
    end
  end

  assign full = (count_q == CNT_W'(FIFO_DEPTH));
  assign pop  = evt_valid & evt_ready;
  assign push = enable & push_hit & (~full | pop);

  // A slot drained this cycle can take a new edge without loss.
  always_comb begin
    pend_v_d = pend_v_q;
    pend_k_d = pend_k_q;
    ovf_set  = 1'b0;
    for (int i = 0; i < N_BTN; i++) begin
      if (push && push_sel == 4'(i)) pend_v_d[i] = 1'b0;
      if (!enable) begin
        pend_v_d[i] = 1'b0;
      end else if (new_ev[i]) begin
        if (pend_v_d[i]) ovf_set = 1'b1;
        pend_v_d[i] = 1'b1;
        pend_k_d[i] = new_kind[i];
      end
    end
    overflow_d = ovf_set | (overflow_q & ~clr_overflow);
  end

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clkin or negedge resetn) begin
    if (!resetn) begin
      pend_v_q   <= '0;
      overflow_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      for (int i = 0; i < N_BTN; i++) pend_k_q[i] <= KIND_PRESS;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      pend_v_q   <= pend_v_d;
      pend_k_q   <= pend_k_d;
      overflow_q <= overflow_d;
      count_q    <= count_d;
      if (push) begin
        mem_q[wr_ptr_q] <= '{idx: push_sel, kind: push_kind};
        wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
    end
  end

  assign evt_valid = (count_q != '0);
  assign evt_idx   = mem_q[rd_ptr_q].idx;
  assign evt_kind  = mem_q[rd_ptr_q].kind;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_button_reader.sv
// Self-checking bench for button_reader: directed segment table, reset corner cases and random segments
// against a window-based behavioural model (long-press expectations follow BUTTON_READER_LONGPRESS_EN).
module tb_button_reader;
  import button_reader_pkg::*;

  localparam int N = 4;
  localparam int D = 8;
  localparam int L = 32;
`ifdef BUTTON_READER_LONGPRESS_EN
  localparam int LONG_EN = 1;
`else
  localparam int LONG_EN = 0;
`endif

  logic         clkin = 1'b0;
  logic         resetn = 1'b0;
  logic         enable = 1'b1;
  logic [N-1:0] btn_raw = '1;
  logic [N-1:0] btn_level;
  logic         evt_valid;
  logic         evt_ready = 1'b1;
  logic [3:0]   evt_idx;
  logic [1:0]   evt_kind;
  logic         overflow;
  logic         clr_overflow = 1'b0;

  always #5 clkin = ~clkin;

  button_reader #(
    .N_BTN(N), .DEBOUNCE_CYCLES(D), .BTN_ACTIVE_LOW(1'b1), .LONG_CYCLES(L)
  ) dut (
    .clkin(clkin), .resetn(resetn), .enable(enable), .btn_raw(btn_raw),
    .btn_level(btn_level), .evt_valid(evt_valid), .evt_ready(evt_ready),
    .evt_idx(evt_idx), .evt_kind(evt_kind), .overflow(overflow),
    .clr_overflow(clr_overflow)
  );

  int vectors = 0;
  int miscompares = 0;

  // Behavioural model: a level flips once the last D synchronized samples all disagree with it.
  typedef struct { int idx; logic [1:0] kind; } ev_t;
  bit         hist [N][D+2];
  bit         mlevel [N];
  int         rise_at [N];
  int         ecnt = 0;
  bit         pend_v [N];
  logic [1:0] pend_k [N];
  ev_t        fifo [$];
  bit         movf;
  int         pops;

  typedef struct {
    logic [N-1:0] mask;
    int           cycles;
    bit           ready;
    bit           en;
    bit           clr;
    logic [N-1:0] exp_level;
    bit           exp_ovf;
    int           exp_pops;
  } vec_t;
  vec_t tbl [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int b = 0; b < N; b++) begin
      for (int k = 0; k < D + 2; k++) hist[b][k] = 1'b0;
      mlevel[b]  = 1'b0;
      rise_at[b] = 0;
      pend_v[b]  = 1'b0;
      pend_k[b]  = 2'b00;
    end
    fifo.delete();
    movf = 1'b0;
  endtask

  task automatic model_edge();
    bit         pop, push, found, ovf_set, all_diff;
    int         j;
    bit         nev [N];
    logic [1:0] nk [N];
    ev_t        e;
    ecnt++;
    pop   = (fifo.size() > 0) && evt_ready;
    found = 1'b0;
    j     = 0;
    for (int b = N - 1; b >= 0; b--) if (pend_v[b]) begin found = 1'b1; j = b; end
    push = enable && found && (fifo.size() < 4 || pop);
    for (int b = 0; b < N; b++) begin
      for (int k = D + 1; k > 0; k--) hist[b][k] = hist[b][k-1];
      hist[b][0] = ~btn_raw[b];
      all_diff = 1'b1;
      for (int k = 2; k <= D + 1; k++) if (hist[b][k] == mlevel[b]) all_diff = 1'b0;
      nev[b] = 1'b0;
      nk[b]  = 2'b00;
      if (all_diff) begin
        mlevel[b] = ~mlevel[b];
        nev[b]    = 1'b1;
        nk[b]     = mlevel[b] ? KIND_PRESS : KIND_RELEASE;
        if (mlevel[b]) rise_at[b] = ecnt;
      end else if (LONG_EN != 0 && mlevel[b] && (ecnt - rise_at[b]) == L) begin
        nev[b] = 1'b1;
        nk[b]  = KIND_LONG;
      end
    end
    if (pop) void'(fifo.pop_front());
    if (push) begin
      e.idx  = j;
      e.kind = pend_k[j];
      fifo.push_back(e);
      pend_v[j] = 1'b0;
    end
    ovf_set = 1'b0;
    for (int b = 0; b < N; b++) begin
      if (!enable) pend_v[b] = 1'b0;
      else if (nev[b]) begin
        if (pend_v[b]) ovf_set = 1'b1;
        pend_v[b] = 1'b1;
        pend_k[b] = nk[b];
      end
    end
    if (ovf_set) movf = 1'b1;
    else if (clr_overflow) movf = 1'b0;
  endtask

  task automatic compare_all();
    logic [N-1:0] lv;
    for (int b = 0; b < N; b++) lv[b] = mlevel[b];
    check("btn_level", btn_level, lv);
    check("evt_valid", evt_valid, fifo.size() > 0);
    check("overflow", overflow, movf);
    if (fifo.size() > 0) begin
      check("evt_idx", evt_idx, fifo[0].idx);
      check("evt_kind", evt_kind, fifo[0].kind);
    end
  endtask

  // Called just after a falling edge; inputs are stable until the next falling edge.
  task automatic step();
    if (evt_valid && evt_ready) pops++;
    @(posedge clkin);
    model_edge();
    @(negedge clkin);
    compare_all();
  endtask

  task automatic apply(input vec_t v);
    btn_raw      = ~v.mask;
    evt_ready    = v.ready;
    enable       = v.en;
    clr_overflow = v.clr;
    pops         = 0;
    repeat (v.cycles) step();
  endtask

  initial begin
    model_reset();
    repeat (3) @(negedge clkin);
    check("reset_valid", evt_valid, 1'b0);
    check("reset_idx", evt_idx, 4'd0);
    check("reset_kind", evt_kind, 2'b00);
    check("reset_level", btn_level, '0);
    check("reset_ovf", overflow, 1'b0);
    resetn = 1'b1;

    //                mask   cyc rdy en clr  level  ovf pops
    tbl.push_back('{4'b0100, 10, 1, 1, 0, 4'b0100, 0, 0});  // press btn2 -> level after 10
    tbl.push_back('{4'b0100,  5, 1, 1, 0, 4'b0100, 0, 1});  // its press event drains
    tbl.push_back('{4'b0101,  5, 1, 1, 0, 4'b0100, 0, 0});  // 5-cycle glitch on btn0
    tbl.push_back('{4'b0100, 12, 1, 1, 0, 4'b0100, 0, 0});
    tbl.push_back('{4'b1110, 14, 1, 1, 0, 4'b1110, 0, 2});  // btn1 and btn3 together
    tbl.push_back('{4'b0000, 14, 1, 1, 0, 4'b0000, 0, 3});
    tbl.push_back('{4'b1111, 12, 0, 1, 0, 4'b1111, 0, 0});  // consumer stalled
    tbl.push_back('{4'b1111,  4, 0, 1, 0, 4'b1111, 0, 0});  // FIFO now full
    tbl.push_back('{4'b1100, 12, 0, 1, 0, 4'b1100, 0, 0});  // releases wait in slots
    tbl.push_back('{4'b1101, 12, 0, 1, 0, 4'b1101, 1, 0});  // btn0 slot overwritten
    tbl.push_back('{4'b1101,  1, 0, 1, 1, 4'b1101, 0, 0});  // clear overflow
    tbl.push_back('{4'b1101, 12, 1, 1, 0, 4'b1101, 0, 6});  // drain FIFO plus two slots
    tbl.push_back('{4'b1111, 12, 1, 0, 0, 4'b1111, 0, 0});  // disabled: level only
    tbl.push_back('{4'b0000, 16, 1, 1, 0, 4'b0000, 0, 4});
    tbl.push_back('{4'b0001, 40, 1, 1, 0, 4'b0001, 0, 1});  // held 40 cycles
    tbl.push_back('{4'b0000, 20, 1, 1, 0, 4'b0000, 0, 1 + LONG_EN});

    foreach (tbl[t]) begin
      apply(tbl[t]);
      check($sformatf("tbl%0d_level", t), btn_level, tbl[t].exp_level);
      check($sformatf("tbl%0d_ovf", t), overflow, tbl[t].exp_ovf);
      check($sformatf("tbl%0d_pops", t), pops, tbl[t].exp_pops);
    end

    // Three events queued, then reset: everything must vanish at once.
    apply('{4'b0111, 14, 0, 1, 0, 4'b0111, 0, 0});
    check("queued_before_reset", evt_valid, 1'b1);
    resetn = 1'b0;
    #1;
    model_reset();
    check("reset_mid_valid", evt_valid, 1'b0);
    check("reset_mid_level", btn_level, '0);
    check("reset_mid_ovf", overflow, 1'b0);
    @(negedge clkin);
    @(negedge clkin);
    resetn = 1'b1;
    // Buttons held through reset come back as fresh presses.
    apply('{4'b0111, 16, 1, 1, 0, 4'b0111, 0, 3});
    check("held_through_reset_pops", pops, 3);

    for (int s = 0; s < 80; s++) begin
      vec_t v;
      v.mask      = 4'($urandom_range(0, 15));
      v.cycles    = $urandom_range(1, 20);
      v.ready     = ($urandom_range(0, 3) != 0);
      v.en        = ($urandom_range(0, 7) != 0);
      v.clr       = ($urandom_range(0, 5) == 0);
      v.exp_level = '0;
      v.exp_ovf   = 1'b0;
      v.exp_pops  = 0;
      apply(v);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
